// File: rtl/pll_rst_seq_pkg.sv
// Shared types and helpers for the PLL supervisor / reset sequencer.
// Optional lock-loss statistics are controlled by PLL_RST_SEQ_LOCK_STATS_EN in the top.
package pll_rst_seq_pkg;

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } pll_state_t;

  // Width able to hold (largest count - 1); never narrower than one bit.
  function automatic int clog2_max(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pll_rst_seq_sync2.sv
// Two-flop synchroniser with asynchronous active-low reset; output resets to 0.
module pll_rst_seq_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_rst_seq_agilex.sv
// PLL supervisor and reset sequencer running on the free-running reference clock.
// Define PLL_RST_SEQ_LOCK_STATS_EN to build the saturating lock-loss event counter.
module pll_rst_seq_agilex
  import pll_rst_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 100000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3,
  parameter int CNT_W = clog2_max(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES)
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ninit_done,
  input  logic        i_locked,
  input  logic        i_sw_rst,
  output logic        o_pll_rst,
  output logic        o_rst_core,
  output logic        o_fail,
  output logic [1:0]  o_retries,
  output logic [15:0] o_lock_loss_cnt,
  output pll_state_t  o_state_dbg
);

  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRIES);

  logic locked_s;

  pll_rst_seq_sync2 u_lock_sync (
    .clk_i  (i_clk),
    .rst_ni (i_rst_n),
    .d_i    (i_locked),
    .q_o    (locked_s)
  );

  pll_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]       retries_q, retries_d, retries_inc;
  logic             pll_rst_q, rst_core_q, fail_q;
  logic             lock_loss;

  // The shared counter saturates instead of wrapping in the open-ended states.
  assign cnt_inc     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
  assign retries_inc = (retries_q == RETRY_LIMIT) ? retries_q : retries_q + 2'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_inc;
    retries_d = retries_q;
    lock_loss = 1'b0;
    if (i_ninit_done || i_sw_rst) begin
      state_d   = S_PLL_RST;
      cnt_d     = '0;
      retries_d = 2'd0;
    end else begin
      case (state_q)
        S_PLL_RST: begin
          if (cnt_q == PLL_RST_LAST) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end
        end
        S_WAIT_LOCK: begin
          if (locked_s) begin
            state_d = S_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            retries_d = retries_inc;
            state_d   = (retries_inc == RETRY_LIMIT) ? S_FAIL : S_PLL_RST;
            cnt_d     = '0;
          end
        end
        S_STABLE: begin
          // A lock drop here is a glitch during settling, not a failed attempt.
          if (!locked_s) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d   = S_RUN;
            cnt_d     = '0;
            retries_d = 2'd0;
          end
        end
        S_RUN: begin
          if (!locked_s) begin
            state_d   = S_PLL_RST;
            cnt_d     = '0;
            lock_loss = 1'b1;
          end
        end
        S_FAIL: begin
          state_d = S_FAIL;
        end
        default: begin
          state_d = S_PLL_RST;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they move together with it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_PLL_RST;
      cnt_q      <= '0;
      retries_q  <= 2'd0;
      pll_rst_q  <= 1'b1;
      rst_core_q <= 1'b1;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retries_q  <= retries_d;
      pll_rst_q  <= (state_d == S_PLL_RST);
      rst_core_q <= (state_d != S_RUN);
      fail_q     <= (state_d == S_FAIL);
    end
  end

  assign o_pll_rst   = pll_rst_q;
  assign o_rst_core  = rst_core_q;
  assign o_fail      = fail_q;
  assign o_retries   = retries_q;
  assign o_state_dbg = state_q;

`ifdef PLL_RST_SEQ_LOCK_STATS_EN
  logic [15:0] loss_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      loss_cnt_q <= 16'h0;
    end else if (lock_loss && (loss_cnt_q != 16'hFFFF)) begin
      loss_cnt_q <= loss_cnt_q + 16'd1;
    end
  end

  assign o_lock_loss_cnt = loss_cnt_q;
`else
  logic lock_loss_unused;
  assign lock_loss_unused = lock_loss;
  assign o_lock_loss_cnt  = 16'h0;
`endif

endmodule
